// File: rtl/axis_stream_out_adapter.sv
// rtl/axis_stream_out_adapter.sv - frame-buffered result stream to AXI-Stream master with down-sizing
// Buffers one core result frame, serializes W_IN words into W_OUT beats LSB-first, and flags TLAST/done/err.
module axis_stream_out_adapter #(
  parameter int W_IN  = 64,
  parameter int W_OUT = 64,
  parameter int DEPTH = 932,
  parameter int CNT_W = $clog2(DEPTH * (W_IN / W_OUT) + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [2:0]       sec_lvl,
  input  logic             core_valid_i,
  output logic             core_ready_o,
  input  logic [W_IN-1:0]  core_data_i,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W_OUT-1:0] m_data,
  output logic             m_last,
  output logic             done,
  output logic             err,
  output logic             busy
);

  localparam int RATIO = W_IN / W_OUT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW    = $clog2(DEPTH + 1);
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN, ST_DONE} state_t;

  state_t           state;
  logic [W_IN-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    fifo_cnt;
  logic [CNT_W-1:0] len, total, in_cnt, beat_cnt;
  logic [W_IN-1:0]  ser_data;
  logic             ser_valid;
  logic [SW-1:0]    sub_cnt;
  logic             err_q;
  logic             fifo_full, fifo_empty, wr_en, rd_en, beat_hs, last_sub, ser_free;

  function automatic logic [CNT_W-1:0] frame_len(input logic [1:0] md, input logic [2:0] sl);
    int n;
    case (md)
      2'd0:    n = (sl == 3'd2) ? 480 : (sl == 3'd3) ? 744 : 932;
      2'd1:    n = 1;
      default: n = (sl == 3'd2) ? 303 : (sl == 3'd3) ? 412 : 575;
    endcase
    return CNT_W'(n);
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full    = (fifo_cnt == OW'(DEPTH));
  assign fifo_empty   = (fifo_cnt == '0);
  assign core_ready_o = (state == ST_FILL) && !fifo_full;
  assign wr_en        = core_valid_i && core_ready_o;
  assign beat_hs      = ser_valid && m_ready;
  assign last_sub     = (sub_cnt == SW'(RATIO - 1));
  // Reloading on the last sub-beat handshake keeps back-to-back words bubble-free.
  assign ser_free     = !ser_valid || (beat_hs && last_sub);
  assign rd_en        = ser_free && !fifo_empty;

  assign m_valid = ser_valid;
  assign m_data  = ser_valid ? ser_data[W_OUT-1:0] : '0;
  assign m_last  = ser_valid && (beat_cnt == total - 1'b1);
  assign done    = (state == ST_DONE);
  assign busy    = (state != ST_IDLE);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (wr_en && !start) mem[wr_ptr] <= core_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      len       <= '0;
      total     <= '0;
      in_cnt    <= '0;
      beat_cnt  <= '0;
      ser_data  <= '0;
      ser_valid <= 1'b0;
      sub_cnt   <= '0;
      err_q     <= 1'b0;
    end else if (start) begin
      // Restart wins over everything, including handshakes in this cycle.
      state     <= ST_FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      len       <= frame_len(mode, sec_lvl);
      total     <= CNT_W'(int'(frame_len(mode, sec_lvl)) * RATIO);
      in_cnt    <= '0;
      beat_cnt  <= '0;
      ser_data  <= '0;
      ser_valid <= 1'b0;
      sub_cnt   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (core_valid_i && !core_ready_o && state != ST_IDLE) err_q <= 1'b1;
      if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
        in_cnt <= in_cnt + 1'b1;
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (rd_en) begin
        ser_data  <= mem[rd_ptr];
        ser_valid <= 1'b1;
        sub_cnt   <= '0;
      end else if (beat_hs) begin
        ser_data <= ser_data >> W_OUT;
        sub_cnt  <= sub_cnt + 1'b1;
        if (last_sub) ser_valid <= 1'b0;
      end
      if (beat_hs) beat_cnt <= beat_cnt + 1'b1;
      case (state)
        ST_FILL:  if (wr_en && in_cnt == len - 1'b1) state <= ST_DRAIN;
        ST_DRAIN: if (beat_hs && m_last) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= state;
      endcase
    end
  end

endmodule

// File: doc/axis_stream_out_adapter.md
Name: axis_stream_out_adapter

Overview:
- Parametrised output adapter between the Dilithium core's result stream and an external AXI-Stream master port.
- Buffers a whole result frame in a FIFO and optionally down-sizes the word width (W_IN to W_OUT, LSB-first).
- Derives the frame length from mode/sec_lvl and asserts last on exactly the final output beat.
- Adds abort-on-restart, a protocol-error flag and a done pulse.

Parameters:
W_IN, 64, input word width from the core.
W_OUT, 64, external stream width; W_IN % W_OUT == 0, RATIO = W_IN/W_OUT (1, 2 or 4 supported).
DEPTH, 932, FIFO depth in W_IN words; must be >= largest table entry.
CNT_W, $clog2(DEPTH*RATIO+1), width of the frame and beat counters.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse: begin new frame, aborts any frame in progress.
mode  in  2  operation: 0 keygen, 1 verify, 2/3 sign.
sec_lvl  in  3  security level 2, 3 or 5; any other value is treated as 5.
core_valid_i  in  1  core result word valid.
core_ready_o  out  1  adapter accepts core word.
core_data_i  in  W_IN  core result word.
m_valid  out  1  AXI-Stream TVALID.
m_ready  in  1  AXI-Stream TREADY.
m_data  out  W_OUT  AXI-Stream TDATA.
m_last  out  1  AXI-Stream TLAST.
done  out  1  one-cycle pulse after the final beat handshake.
err  out  1  sticky: core_valid_i seen while core_ready_o low outside IDLE.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE; FIFO empty; counters 0; serializer empty. core_ready_o, m_valid, m_last, done, err and busy are all 0. m_data is 0.
- Length table, in W_IN words, latched at start:
  - mode 0: 480 / 744 / 932 for sec_lvl 2 / 3 / other.
  - mode 1: 1.
  - mode 2 or 3: 303 / 412 / 575.
  - Beat total = len*RATIO.
- FSM states: IDLE, FILL, DRAIN, DONE.
  - IDLE -> FILL on start.
  - FILL -> DRAIN when the len-th input word is accepted.
  - DRAIN -> DONE on handshake of the final beat.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
- start in any state, including the same cycle as a handshake:
  - flush FIFO and serializer; zero counters; clear err; latch new len; go to FILL.
  - The handshake in that cycle is discarded on both sides.
- core_ready_o = (state==FILL) && !fifo_full. This is combinational from registered state. A write occurs on core_valid_i && core_ready_o.
- Input counter increments per accepted word. core_ready_o drops the cycle after the len-th accept.
- Serializer:
  - Loads the FIFO head when empty, or in the same cycle as its last sub-beat handshakes, so back-to-back streaming runs with no bubble.
  - Emits the word as RATIO beats, bits [W_OUT-1:0] first.
  - First-word latency: beat is valid 2 cycles after core accept (FIFO write + serializer load).
- m_valid = serializer holds a beat.
  - Once m_valid is high, m_data, m_last and m_valid stay stable until m_ready (AXI rule).
  - m_valid never deasserts without a handshake, except on start or reset.
- Beat counter increments on m_valid && m_ready. m_last = m_valid && (beat_cnt == total-1). No beat is emitted after the last one.
- FIFO:
  - Simultaneous read and write when not full or empty is allowed; occupancy is unchanged.
  - A write at full is impossible by construction of core_ready_o.
  - A read at empty leaves the serializer empty.
- err: set when core_valid_i && !core_ready_o && state!=IDLE. Stays set until start or reset. The offending word is dropped.
- Async reset mid-frame returns everything to reset values immediately. The first rising edge after release sees IDLE.

Test Plan:
- W_OUT=64, mode=1, start, one core word 0xDEAD_BEEF_0123_4567, m_ready=1 -> one beat with that data and m_last=1; done pulse on the next cycle; busy falls with done.
- W_OUT=32, mode=1, word 0x1111_2222_3333_4444 -> beats 0x3333_4444 (last=0) then 0x1111_2222 (last=1).
- mode=0, sec_lvl=2, W_OUT=64, core streaming continuously, random m_ready at 50% -> exactly 480 beats in order; m_last only on beat 480; m_data stable while stalled; core_ready_o low after accept 480.
- mode=2, sec_lvl=5, m_ready=0 throughout fill -> 575 words accepted with no drops and err=0; then with m_ready=1, 575 beats and last on the 575th.
- start pulse after 100 of 744 words (mode 0, sec 3) -> FIFO flushed, m_valid low next cycle, new frame length in effect, no stale data emitted.
- core_valid_i held high after the final word is accepted -> err=1 and stays 1 until start; output frame unaffected. Assert rst_n low mid-DRAIN -> all outputs 0 asynchronously.
